// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: round counts, round-mode
// encodings and the controller state enum.
package aes_pkg;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_256 = 14;

  localparam logic [1:0] RND_ARK   = 2'b00;
  localparam logic [1:0] RND_FULL  = 2'b01;
  localparam logic [1:0] RND_FINAL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } ctrl_state_e;

  // Round 0 is the initial key whitening; the last round skips MixColumns.
  function automatic logic [1:0] mode_of(input logic is_first, input logic is_last);
    logic [1:0] m;
    if (is_first) begin
      m = RND_ARK;
    end else if (is_last) begin
      m = RND_FINAL;
    end else begin
      m = RND_FULL;
    end
    return m;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in, round-datapath and ciphertext-out signals of aes_round_ctrl.
// key_len exists only when AES_KEY256_EN is defined.
interface aes_round_ctrl_if #(
  parameter int DATA_W = 128
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
`ifdef AES_KEY256_EN
  logic              key_len;
`endif
  logic              rnd_valid;
  logic [DATA_W-1:0] rnd_data;
  logic [1:0]        rnd_mode;
  logic [3:0]        rnd_key_idx;
  logic              rnd_ret_valid;
  logic [DATA_W-1:0] rnd_ret_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              err;

  modport master (
`ifdef AES_KEY256_EN
    input  key_len,
`endif
    input  in_valid, in_data, rnd_ret_valid, rnd_ret_data, out_ready,
    output in_ready, rnd_valid, rnd_data, rnd_mode, rnd_key_idx,
    output out_valid, out_data, busy, err
  );

  modport slave (
`ifdef AES_KEY256_EN
    output key_len,
`endif
    output in_valid, in_data, rnd_ret_valid, rnd_ret_data, out_ready,
    input  in_ready, rnd_valid, rnd_data, rnd_mode, rnd_key_idx,
    input  out_valid, out_data, busy, err
  );

endinterface

// File: rtl/aes_round_cnt.sv
// Round counter for the AES round controller: cleared on block accept,
// stepped once per completed round, with first/last-round decode.
module aes_round_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       inc,
  input  logic [3:0] last,
  output logic [3:0] rnd,
  output logic       is_first,
  output logic       is_last
);

  logic [3:0] rnd_r;

  // Counter register; the controller never steps past the last round.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rnd_r <= 4'd0;
    end else if (load) begin
      rnd_r <= 4'd0;
    end else if (inc) begin
      rnd_r <= rnd_r + 4'd1;
    end else begin
      rnd_r <= rnd_r;
    end
  end

  assign rnd      = rnd_r;
  assign is_first = (rnd_r == 4'd0);
  assign is_last  = (rnd_r == last);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: owns the shared round datapath for one block
// at a time. Defining AES_KEY256_EN adds a per-block key_len select (10/14 rounds).
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int NR     = NR_128
) (
  input logic              clk,
  input logic              reset,
  aes_round_ctrl_if.master bus
);

  ctrl_state_e       state_r;
  ctrl_state_e       state_nxt_s;
  logic [DATA_W-1:0] blk_r;
  logic              ready_en_r;
  logic              err_r;
  logic              accept_s;
  logic              ret_take_s;
  logic              load_s;
  logic              inc_s;
  logic [3:0]        rnd_s;
  logic [3:0]        last_s;
  logic              is_first_s;
  logic              is_last_s;

`ifdef AES_KEY256_EN
  logic key_len_r;

  // Key length is frozen for the whole block at accept time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_len_r <= 1'b0;
    end else if (accept_s) begin
      key_len_r <= bus.key_len;
    end else begin
      key_len_r <= key_len_r;
    end
  end

  assign last_s = key_len_r ? 4'(NR_256) : 4'(NR);
`else
  assign last_s = 4'(NR);
`endif

  assign accept_s   = bus.in_valid & bus.in_ready;
  assign ret_take_s = (state_r == S_WAIT) & bus.rnd_ret_valid;

  aes_round_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .inc      (inc_s),
    .last     (last_s),
    .rnd      (rnd_s),
    .is_first (is_first_s),
    .is_last  (is_last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_ISSUE;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (bus.rnd_ret_valid) begin
          if (is_last_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_ISSUE;
            inc_s       = 1'b1;
          end
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // in_ready stays low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      err_r      <= err_r | (bus.rnd_ret_valid & (state_r != S_WAIT));
    end
  end

  // Block state: plaintext on accept, then each round result in turn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_r <= '0;
    end else if (accept_s) begin
      blk_r <= bus.in_data;
    end else if (ret_take_s) begin
      blk_r <= bus.rnd_ret_data;
    end else begin
      blk_r <= blk_r;
    end
  end

  assign bus.in_ready    = (state_r == S_IDLE) & ready_en_r;
  assign bus.rnd_valid   = (state_r == S_ISSUE);
  assign bus.rnd_mode    = (state_r == S_ISSUE) ? mode_of(is_first_s, is_last_s) : RND_ARK;
  assign bus.rnd_key_idx = rnd_s;
  assign bus.rnd_data    = blk_r;
  assign bus.out_valid   = (state_r == S_DONE);
  assign bus.out_data    = blk_r;
  assign bus.busy        = (state_r != S_IDLE);
  assign bus.err         = err_r;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative round sequencer for the AES-128 encryption core. It accepts one 128-bit plaintext block over a valid/ready handshake and feeds that block through the shared single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) once per round. Each round it selects the round mode and the round-key index. After the final round it presents the ciphertext on an output valid/ready handshake. It sits between the block input FIFO and the output register stage and is the only master of the round datapath.

## Interface
- DATA_W, 128, block width in bits; fixed at 128.
- NR, 10, number of AES rounds for AES-128.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  input block available.
- in_ready  out  1  controller can accept a block.
- in_data  in  DATA_W  plaintext block.
- rnd_valid  out  1  issue strobe to the round datapath, one cycle per round.
- rnd_data  out  DATA_W  state sent to the datapath.
- rnd_mode  out  2  round mode: 00 = AddRoundKey only, 01 = full round, 10 = final round (no MixColumns).
- rnd_key_idx  out  4  round-key index, 0..NR.
- rnd_ret_valid  in  1  datapath result valid.
- rnd_ret_data  in  DATA_W  datapath result.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  DATA_W  ciphertext.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky flag: unexpected rnd_ret_valid.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and DONE.
- An internal state register holds the block; a 4-bit round counter `rnd` tracks progress.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the state register, set rnd=0, go to ISSUE.
- ISSUE:
  - rnd_valid=1 for exactly one cycle; rnd_data = state register; rnd_key_idx = rnd.
  - rnd_mode = 00 when rnd==0, 10 when rnd==NR, otherwise 01.
  - Always go to WAIT next.
- WAIT:
  - On rnd_ret_valid: latch rnd_ret_data into the state register.
  - If rnd==NR, go to DONE; otherwise increment rnd and go to ISSUE.
- DONE:
  - out_valid=1; out_data = state register.
  - out_data stays stable while out_valid&&!out_ready.
  - On out_ready, go to IDLE.
- in_ready is 0 in every state except IDLE. in_valid in those states is ignored; there is no queuing.
- rnd_ret_valid in IDLE, ISSUE or DONE is ignored and sets err. err clears only on reset.
- The round counter never wraps, because it is bounded by NR.
- Out-of-range rnd_mode encoding 11 is never driven.

## Timing
- Reset values: in_ready=0 while reset is asserted and 1 from the first cycle after release; rnd_valid=0, rnd_mode=00, rnd_key_idx=0, out_valid=0, busy=0, err=0; rnd_data and out_data are 0.
- rnd_valid, rnd_mode, rnd_key_idx, in_ready, out_valid and busy are decoded from registered state; no input-to-output combinational path.
- Datapath latency L ≥ 1 cycles, measured from rnd_valid high to rnd_ret_valid high. Each round costs L+1 cycles.
- Accept cycle = cycle 0. out_valid first goes high in cycle (NR+1)(L+1)+1. For L=1, NR=10 this is cycle 23.
- Output handshake in cycle t: IDLE in t+1, and in_ready=1 in t+1. There is no same-cycle turnaround.
- Reset mid-operation returns the FSM to IDLE immediately and discards the block. The datapath shares the same reset, so no stale result returns.

## Configuration
- AES_KEY256_EN defined:
  - Adds input key_len (1 bit; 0 = AES-128, 1 = AES-256), latched on accept.
  - The effective round count is 10 or 14; rnd_key_idx spans 0..14.
  - Latency uses the latched round count.
- Not defined: key_len is absent and the round count is fixed at NR.

## Structure
- Shared package aes_pkg holds:
  - NR_128=10 and NR_256=14;
  - rnd_mode encodings RND_ARK, RND_FULL, RND_FINAL;
  - the FSM state enum.
- One sub-module, aes_round_cnt: round counter with load, increment and an is_first/is_last decode feeding rnd_mode.
- The datapath stages are external; this block contains no AES arithmetic.

## Test plan
- Single block, L=1, out_ready held at 1, FIPS-197 vector with plaintext 00112233445566778899aabbccddeeff: expect 11 rnd_valid pulses with key_idx 0..10 and modes 00, 01×9, 10; expect out_valid in cycle 23 with out_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable throughout; in_ready=0 throughout; handshake completes on the 6th cycle.
- Back-to-back: in_valid held high with two blocks -> second accepted exactly 1 cycle after the first output handshake; no rnd_valid overlap between blocks.
- Spurious rnd_ret_valid pulsed in IDLE -> err=1 and the state register is unchanged; a following block still completes correctly.
- Reset asserted during WAIT of round 5 -> all outputs return to reset values asynchronously; a new block after release completes normally.
- Compiled with AES_KEY256_EN, key_len=1, L=2 -> 15 issues with key_idx 0..14; out_valid in cycle 46.
